// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port RAM interface between the instruction-fetch (IF)
//   requester and the data (MEM) requester. MEM has priority. A streak counter
//   forces an IF grant after MAX_STREAK consecutive MEM grants that happened
//   while IF was waiting. An in-flight fetch can be killed on a redirect. The
//   RAM handshake still completes, but no if_done is produced for that fetch.
//
// Handshake semantics (all ports):
//   Requesters raise *_req with stable address/data and hold it until the
//   matching *_done pulse (or, for IF, a kill). *_done is a one-cycle
//   registered pulse. In the cycle it is visible the arbiter is already IDLE
//   and arbitrates on whatever the requesters present in that cycle.
//   ram_req is held from the cycle after the grant until ram_ack is sampled.
//   ram_ack is a single-cycle completion that carries ram_rdata.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr/if_kill    fetch request, address, redirect kill
//   if_done/if_rdata          fetch completion pulse and data
//   mem_req/we/addr/wdata/wmask  data request (load or masked store)
//   mem_done/mem_rdata        data completion pulse and load data
//   ram_req/we/addr/wdata/wmask  RAM request side
//   ram_ack/ram_rdata         RAM completion side
//   dbg_state                 current FSM state (0=IDLE, 1=BUSY_IF, 2=BUSY_MEM)
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_wmask,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] ram_wmask,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_e              state_q;
  logic [3:0]          streak_q, streak_d;
  logic                kill_pend_q;
  logic                ram_req_q, ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wmask_q;
  logic                if_done_q, mem_done_q;
  logic [DATA_W-1:0]   if_rdata_q, mem_rdata_q;

  logic force_if, grant_mem, grant_if;

  // IF has waited through MAX_STREAK MEM grants, so MEM yields this time.
  assign force_if  = if_req && (streak_q >= STREAK_MAX);
  assign grant_mem = (state_q == IDLE) && mem_req && !force_if;
  // A kill in the decision cycle suppresses the fetch grant for that cycle.
  assign grant_if  = (state_q == IDLE) && !grant_mem && if_req && !if_kill;

  // The streak counts only MEM grants that made a waiting IF lose. It clears
  // whenever IF is served or IF is not asking at all.
  always_comb begin
    streak_d = streak_q;
    if (state_q == IDLE) begin
      if (grant_if || !if_req) begin
        streak_d = 4'd0;
      end else if (grant_mem && (streak_q < STREAK_MAX)) begin
        streak_d = streak_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      kill_pend_q <= 1'b0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wmask_q <= '0;
      if_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      streak_q   <= streak_d;
      case (state_q)
        IDLE: begin
          // ram_ack seen here is stale or spurious and is ignored.
          if (grant_mem) begin
            ram_req_q   <= 1'b1;
            ram_we_q    <= mem_we;
            ram_addr_q  <= mem_addr;
            ram_wdata_q <= mem_wdata;
            ram_wmask_q <= mem_wmask;
            state_q     <= BUSY_MEM;
          end else if (grant_if) begin
            ram_req_q   <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= if_addr;
            ram_wdata_q <= '0;
            ram_wmask_q <= '0;
            state_q     <= BUSY_IF;
          end
        end
        BUSY_IF: begin
          if (if_kill) kill_pend_q <= 1'b1;
          if (ram_ack) begin
            // A kill in the ack cycle itself also drops the result.
            if (!kill_pend_q && !if_kill) begin
              if_done_q  <= 1'b1;
              if_rdata_q <= ram_rdata;
            end
            kill_pend_q <= 1'b0;
            ram_req_q   <= 1'b0;
            state_q     <= IDLE;
          end
        end
        BUSY_MEM: begin
          if (ram_ack) begin
            mem_done_q <= 1'b1;
            if (!ram_we_q) mem_rdata_q <= ram_rdata;
            ram_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wmask = ram_wmask_q;
  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a RAM responder with programmable ack
// latency, requester driver tasks, and queues of expected grants and done data
// that a negedge monitor pops as the DUT produces them.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, if_kill = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          mem_req = 1'b0, mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0, mem_wmask = '0;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;
  logic          ram_req, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_wmask;
  logic          ram_ack = 1'b0;
  logic [DW-1:0] ram_rdata = '0;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, expected summary before it");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
  } gnt_t;

  int            vectors = 0;
  int            miscompares = 0;
  gnt_t          gnt_q[$];
  logic [DW-1:0] if_exp_q[$];
  logic [DW-1:0] mem_exp_q[$];
  logic [DW-1:0] last_load = '0;

  int   ram_lat = 1;
  int   ram_cnt = 0;
  logic spurious_ack = 1'b0;
  logic model_ack;
  logic ram_req_prev = 1'b0;

  function automatic logic [DW-1:0] ram_model(input logic [AW-1:0] a);
    if (a == 64'h8000_0000) return 64'h13;
    return {a[31:0], ~a[31:0]} ^ 64'h0F0F_0000_0000_F0F0;
  endfunction

  function automatic gnt_t mk_gnt(input logic we, input logic [AW-1:0] a,
                                  input logic [DW-1:0] wd, input logic [DW-1:0] wm);
    gnt_t g;
    g.we = we; g.addr = a; g.wdata = wd; g.wmask = wm;
    return g;
  endfunction

  // RAM responder: ack ram_lat cycles after ram_req rises.
  always @(negedge clk) begin
    model_ack = 1'b0;
    if (ram_req) begin
      ram_cnt++;
      if (ram_cnt == ram_lat) begin
        model_ack = 1'b1;
        ram_rdata = ram_model(ram_addr);
      end
    end else begin
      ram_cnt = 0;
    end
    if (spurious_ack) ram_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    ram_ack = model_ack | spurious_ack;
  end

  // Monitor: grants on ram_req rising edge, done pulses as they appear.
  always @(negedge clk) begin
    gnt_t g;
    logic [DW-1:0] e;
    if (rst) begin
      ram_req_prev = 1'b0;
    end else begin
      if (ram_req && !ram_req_prev) begin
        vectors++;
        if (gnt_q.size() == 0) begin
          miscompares++;
          $display("FAIL grant_unexpected: got we=%0b addr=%h, expected no grant", ram_we, ram_addr);
        end else begin
          g = gnt_q.pop_front();
          if (ram_we !== g.we || ram_addr !== g.addr || ram_wmask !== g.wmask ||
              (g.we && ram_wdata !== g.wdata)) begin
            miscompares++;
            $display("FAIL grant: got we=%0b addr=%h wdata=%h wmask=%h, expected we=%0b addr=%h wdata=%h wmask=%h",
                     ram_we, ram_addr, ram_wdata, ram_wmask, g.we, g.addr, g.wdata, g.wmask);
          end
        end
      end
      ram_req_prev = ram_req;
      if (if_done) begin
        vectors++;
        if (if_exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL if_done_unexpected: got if_rdata=%h, expected no if_done", if_rdata);
        end else begin
          e = if_exp_q.pop_front();
          if (if_rdata !== e) begin
            miscompares++;
            $display("FAIL if_rdata: got %h, expected %h", if_rdata, e);
          end
        end
      end
      if (mem_done) begin
        vectors++;
        if (mem_exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL mem_done_unexpected: got mem_rdata=%h, expected no mem_done", mem_rdata);
        end else begin
          e = mem_exp_q.pop_front();
          if (mem_rdata !== e) begin
            miscompares++;
            $display("FAIL mem_rdata: got %h, expected %h", mem_rdata, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_if(input logic [AW-1:0] a);
    int n = 0;
    if_addr = a;
    if_req  = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!if_done && n < 100);
    if (!if_done) begin
      vectors++; miscompares++;
      $display("FAIL if_timeout: if_done=0 after %0d cycles, expected 1", n);
    end
    if_req = 1'b0;
  endtask

  // keep=1 leaves mem_req high so the caller can present the next request
  // in the done cycle.
  task automatic drive_mem(input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                           input logic keep);
    int n = 0;
    mem_we = we; mem_addr = a; mem_wdata = wd; mem_wmask = wm;
    mem_req = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!mem_done && n < 100);
    if (!mem_done) begin
      vectors++; miscompares++;
      $display("FAIL mem_timeout: mem_done=0 after %0d cycles, expected 1", n);
    end
    if (!keep) mem_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({ram_req, ram_we, if_done, mem_done} !== 4'b0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got req=%0b we=%0b if_done=%0b mem_done=%0b state=%0d, expected all 0",
               ram_req, ram_we, if_done, mem_done, dbg_state);
    end
    vectors++;
    if ((ram_addr | ram_wdata | ram_wmask | if_rdata | mem_rdata) !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_data: got addr=%h wdata=%h wmask=%h if_rdata=%h mem_rdata=%h, expected 0",
               ram_addr, ram_wdata, ram_wmask, if_rdata, mem_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_fetch;
    int n = 0;
    ram_lat = 2;
    gnt_q.push_back(mk_gnt(1'b0, 64'h8000_0000, '0, '0));
    if_exp_q.push_back(64'h13);
    if_addr = 64'h8000_0000;
    if_req  = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!if_done && n < 50);
    if_req = 1'b0;
    vectors++;
    if (n !== 3) begin
      miscompares++;
      $display("FAIL fetch_latency: got %0d cycles to if_done, expected 3", n);
    end
    vectors++;
    if (ram_req !== 1'b0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL fetch_release: got ram_req=%0b state=%0d, expected 0/0", ram_req, dbg_state);
    end
    @(posedge clk); #1;
    vectors++;
    if (if_done !== 1'b0 || ram_req !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_pulse: got if_done=%0b ram_req=%0b a cycle later, expected 0/0", if_done, ram_req);
    end
  endtask

  task automatic test_contention;
    ram_lat = 1;
    gnt_q.push_back(mk_gnt(1'b0, 64'h8000_1000, '0, '0));
    gnt_q.push_back(mk_gnt(1'b0, 64'h8000_0040, '0, '0));
    mem_exp_q.push_back(ram_model(64'h8000_1000));
    if_exp_q.push_back(ram_model(64'h8000_0040));
    last_load = ram_model(64'h8000_1000);
    fork
      drive_mem(1'b0, 64'h8000_1000, '0, '0, 1'b0);
      drive_if(64'h8000_0040);
    join
  endtask

  task automatic test_store;
    ram_lat = $urandom_range(3, 1);
    gnt_q.push_back(mk_gnt(1'b1, 64'h8000_2008, 64'hDEAD_BEEF, 64'hFFFF_FFFF));
    mem_exp_q.push_back(last_load);
    drive_mem(1'b1, 64'h8000_2008, 64'hDEAD_BEEF, 64'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_starvation;
    logic [AW-1:0] a;
    ram_lat = $urandom_range(2, 1);
    for (int i = 0; i < 6; i++) begin
      a = 64'h8000_3000 + 64'(i * 8);
      if (i == 4) gnt_q.push_back(mk_gnt(1'b0, 64'h8000_0100, '0, '0));
      gnt_q.push_back(mk_gnt(1'b0, a, '0, '0));
      mem_exp_q.push_back(ram_model(a));
      last_load = ram_model(a);
    end
    if_exp_q.push_back(ram_model(64'h8000_0100));
    fork
      begin
        for (int i = 0; i < 6; i++)
          drive_mem(1'b0, 64'h8000_3000 + 64'(i * 8), '0, '0, i < 5);
      end
      drive_if(64'h8000_0100);
    join
  endtask

  task automatic test_kill;
    ram_lat = 3;
    gnt_q.push_back(mk_gnt(1'b0, 64'h8000_0200, '0, '0));
    gnt_q.push_back(mk_gnt(1'b0, 64'h8000_0800, '0, '0));
    if_exp_q.push_back(ram_model(64'h8000_0800));
    if_addr = 64'h8000_0200;
    if_req  = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (dbg_state !== 2'd1) begin
      miscompares++;
      $display("FAIL kill_busy: got state=%0d, expected 1", dbg_state);
    end
    if_kill = 1'b1;
    if_addr = 64'h8000_0800;
    @(posedge clk); #1;
    if_kill = 1'b0;
    vectors++;
    if (ram_req !== 1'b1) begin
      miscompares++;
      $display("FAIL kill_hold: got ram_req=%0b after kill, expected 1", ram_req);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dbg_state !== 2'd0 || if_done !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_ack: got state=%0d if_done=%0b after ack, expected 0/0", dbg_state, if_done);
    end
    @(posedge clk); #1;
    vectors++;
    if (ram_req !== 1'b1 || ram_addr !== 64'h8000_0800) begin
      miscompares++;
      $display("FAIL kill_regrant: got ram_req=%0b addr=%h, expected 1/%h", ram_req, ram_addr, 64'h8000_0800);
    end
    drive_if(64'h8000_0800);
  endtask

  task automatic test_kill_idle;
    ram_lat = 1;
    if_addr = 64'h8000_0C00;
    if_req  = 1'b1;
    if_kill = 1'b1;
    @(posedge clk); #1;
    if_kill = 1'b0;
    vectors++;
    if (ram_req !== 1'b0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL kill_idle: got ram_req=%0b state=%0d, expected 0/0", ram_req, dbg_state);
    end
    gnt_q.push_back(mk_gnt(1'b0, 64'h8000_0C00, '0, '0));
    if_exp_q.push_back(ram_model(64'h8000_0C00));
    drive_if(64'h8000_0C00);
  endtask

  task automatic test_reset_midop;
    ram_lat = 8;
    gnt_q.push_back(mk_gnt(1'b0, 64'h8000_4000, '0, '0));
    mem_we = 1'b0; mem_addr = 64'h8000_4000; mem_req = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (dbg_state !== 2'd2) begin
      miscompares++;
      $display("FAIL midop_busy: got state=%0d, expected 2", dbg_state);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_load = '0;
    spurious_ack = 1'b1;
    @(posedge clk); #1;
    spurious_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if ({ram_req, mem_done, if_done} !== 3'b0 || dbg_state !== 2'd0 ||
          (ram_addr | mem_rdata | if_rdata) !== 64'h0) begin
        miscompares++;
        $display("FAIL midop_idle: got req=%0b mem_done=%0b if_done=%0b state=%0d addr=%h mem_rdata=%h, expected all 0",
                 ram_req, mem_done, if_done, dbg_state, ram_addr, mem_rdata);
      end
    end
  endtask

  task automatic test_drain;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (gnt_q.size() !== 0 || if_exp_q.size() !== 0 || mem_exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL drain: got %0d grants %0d if %0d mem still expected, expected 0/0/0",
               gnt_q.size(), if_exp_q.size(), mem_exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_store();
    test_starvation();
    test_kill();
    test_kill_idle();
    test_reset_midop();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
